// File: rtl/mp_pma_rcv_det_seq.sv
// mp_pma_rcv_det_seq: PMA receiver-detect sequencer driving analog detect phases and majority-voting the comparator
module mp_pma_rcv_det_seq #(
  parameter int CNT_W       = 12,
  parameter int NUM_SAMPLES = 8
) (
  input  logic             ref_clk,
  input  logic             ref_rst,
  input  logic             pma_rcv_detect,
  output logic             pma_rcv_detect_done,
  output logic             pma_rcv_detected,
  input  logic [CNT_W-1:0] cfg_settle_cnt,
  input  logic [CNT_W-1:0] cfg_pulse_cnt,
  input  logic [CNT_W-1:0] cfg_charge_cnt,
  output logic             ana_rxdet_en,
  output logic             ana_rxdet_pulse,
  input  logic             ana_rxdet_comp,
  output logic             rcv_det_busy
);
  localparam int ACC_W = $clog2(NUM_SAMPLES) + 1;
  localparam int CW    = CNT_W > ACC_W ? CNT_W : ACC_W;
  typedef enum logic [2:0] {IDLE, SETTLE, PULSE, CHARGE, SAMPLE, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic comp_s1, comp_s2, cnt_z;
  logic en_nx, pulse_nx, done_nx, det_nx;
  assign cnt_z = cnt == '0;
  assign rcv_det_busy = state != IDLE;
  always_ff @(posedge ref_clk) begin
    if (ref_rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      acc                 <= '0;
      comp_s1             <= 1'b0;
      comp_s2             <= 1'b0;
      ana_rxdet_en        <= 1'b0;
      ana_rxdet_pulse     <= 1'b0;
      pma_rcv_detect_done <= 1'b0;
      pma_rcv_detected    <= 1'b0;
    end else begin
      state               <= state_nx;
      cnt                 <= cnt_nx;
      acc                 <= acc_nx;
      comp_s1             <= ana_rxdet_comp;
      comp_s2             <= comp_s1;
      ana_rxdet_en        <= en_nx;
      ana_rxdet_pulse     <= pulse_nx;
      pma_rcv_detect_done <= done_nx;
      pma_rcv_detected    <= det_nx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pma_rcv_detect ? SETTLE : IDLE;
      SETTLE:  state_nx = !pma_rcv_detect ? IDLE : cnt_z ? PULSE : SETTLE;
      PULSE:   state_nx = !pma_rcv_detect ? IDLE : cnt_z ? CHARGE : PULSE;
      CHARGE:  state_nx = !pma_rcv_detect ? IDLE : cnt_z ? SAMPLE : CHARGE;
      SAMPLE:  state_nx = !pma_rcv_detect ? IDLE : cnt_z ? DONE : SAMPLE;
      DONE:    state_nx = pma_rcv_detect ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cnt_nx   = state == IDLE   ? CW'(cfg_settle_cnt) :
               !cnt_z          ? cnt - 1'b1 :
               state == SETTLE ? CW'(cfg_pulse_cnt) :
               state == PULSE  ? CW'(cfg_charge_cnt) :
               state == CHARGE ? CW'(NUM_SAMPLES - 1) : '0;
    acc_nx   = state == SAMPLE ? acc + ACC_W'(comp_s2) : state == IDLE ? '0 : acc;
    en_nx    = state_nx != IDLE && state_nx != DONE;
    pulse_nx = state_nx == PULSE;
    done_nx  = state_nx == DONE;
    det_nx   = state_nx != DONE ? 1'b0 :
               state == SAMPLE  ? acc_nx >= ACC_W'(NUM_SAMPLES / 2 + 1) : pma_rcv_detected;
  end
endmodule

// File: tb/tb_mp_pma_rcv_det_seq.sv
// tb_mp_pma_rcv_det_seq: directed self-checking bench for the receiver-detect sequencer
module tb_mp_pma_rcv_det_seq;
  logic ref_clk = 1'b0;
  logic ref_rst, pma_rcv_detect, ana_rxdet_comp;
  logic pma_rcv_detect_done, pma_rcv_detected, ana_rxdet_en, ana_rxdet_pulse, rcv_det_busy;
  logic [11:0] cfg_settle_cnt, cfg_pulse_cnt, cfg_charge_cnt;
  int compared = 0;
  int mismatched = 0;
  int first, pulses, bad, unstable, seen;
  mp_pma_rcv_det_seq dut (
    .ref_clk(ref_clk),
    .ref_rst(ref_rst),
    .pma_rcv_detect(pma_rcv_detect),
    .pma_rcv_detect_done(pma_rcv_detect_done),
    .pma_rcv_detected(pma_rcv_detected),
    .cfg_settle_cnt(cfg_settle_cnt),
    .cfg_pulse_cnt(cfg_pulse_cnt),
    .cfg_charge_cnt(cfg_charge_cnt),
    .ana_rxdet_en(ana_rxdet_en),
    .ana_rxdet_pulse(ana_rxdet_pulse),
    .ana_rxdet_comp(ana_rxdet_comp),
    .rcv_det_busy(rcv_det_busy)
  );
  always #5 ref_clk = ~ref_clk;
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ref_clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_done"}, 32'(pma_rcv_detect_done), 0);
    chk({tag, "_det"}, 32'(pma_rcv_detected), 0);
    chk({tag, "_en"}, 32'(ana_rxdet_en), 0);
    chk({tag, "_pulse"}, 32'(ana_rxdet_pulse), 0);
    chk({tag, "_busy"}, 32'(rcv_det_busy), 0);
  endtask
  task automatic run_pat(input string tag, input logic [7:0] pat, input logic other, input logic exp_det);
    ana_rxdet_comp = other;
    tick(3);
    pma_rcv_detect = 1'b1;
    for (int n = 0; n < 12; n++) begin
      ana_rxdet_comp = (n >= 2 && n <= 9) ? pat[n-2] : other;
      tick();
      if (n == 10) chk({tag, "_done_early"}, 32'(pma_rcv_detect_done), 0);
    end
    chk({tag, "_done_at12"}, 32'(pma_rcv_detect_done), 1);
    chk({tag, "_det"}, 32'(pma_rcv_detected), 32'(exp_det));
    pma_rcv_detect = 1'b0;
    tick();
    chk({tag, "_done_clr"}, 32'(pma_rcv_detect_done), 0);
    chk({tag, "_det_clr"}, 32'(pma_rcv_detected), 0);
  endtask
  initial begin
    ref_rst = 1'b1;
    pma_rcv_detect = 1'b0;
    ana_rxdet_comp = 1'b0;
    cfg_settle_cnt = 12'd10;
    cfg_pulse_cnt = 12'd4;
    cfg_charge_cnt = 12'd20;
    tick(3);
    ref_rst = 1'b0;
    chk_idle("rst_init");
    ana_rxdet_comp = 1'b1;
    tick(3);
    pma_rcv_detect = 1'b1;
    first = 0; pulses = 0; bad = 0; unstable = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) chk("en_first_cycle", 32'(ana_rxdet_en), 1);
      if (ana_rxdet_pulse) pulses++;
      if (ana_rxdet_pulse && !ana_rxdet_en) bad++;
      if (first == 0 && pma_rcv_detect_done) first = n;
      if (first != 0 && (!pma_rcv_detect_done || !pma_rcv_detected || ana_rxdet_en || !rcv_det_busy)) unstable++;
      if (first != 0 && n == first + 50) break;
    end
    chk("latency_10_4_20", 32'(first), 46);
    chk("pulse_cycles", 32'(pulses), 5);
    chk("pulse_without_en", 32'(bad), 0);
    chk("detected_stuck1", 32'(pma_rcv_detected), 1);
    chk("done_hold_stable", 32'(unstable), 0);
    pma_rcv_detect = 1'b0;
    tick();
    chk_idle("hs_release");
    pma_rcv_detect = 1'b1;
    tick(13);
    chk("mid_pulse", 32'(ana_rxdet_pulse), 1);
    ref_rst = 1'b1;
    tick(3);
    chk_idle("rst_pulse");
    pma_rcv_detect = 1'b0;
    ref_rst = 1'b0;
    tick();
    cfg_settle_cnt = 12'd0;
    cfg_pulse_cnt = 12'd0;
    cfg_charge_cnt = 12'd0;
    run_pat("maj5of8", 8'b1011_0101, 1'b0, 1'b1);
    run_pat("maj4of8", 8'b0110_1001, 1'b1, 1'b0);
    run_pat("all0", 8'b0000_0000, 1'b0, 1'b0);
    run_pat("all1", 8'b1111_1111, 1'b0, 1'b1);
    cfg_settle_cnt = 12'd3;
    cfg_pulse_cnt = 12'd2;
    cfg_charge_cnt = 12'd5;
    ana_rxdet_comp = 1'b1;
    pma_rcv_detect = 1'b1;
    tick(9);
    chk("abort_in_charge_en", 32'(ana_rxdet_en), 1);
    chk("abort_in_charge_pulse", 32'(ana_rxdet_pulse), 0);
    pma_rcv_detect = 1'b0;
    tick();
    chk("abort_en_off", 32'(ana_rxdet_en), 0);
    chk("abort_busy_off", 32'(rcv_det_busy), 0);
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (pma_rcv_detect_done || pma_rcv_detected || ana_rxdet_en) seen++;
    end
    chk("abort_no_done", 32'(seen), 0);
    pma_rcv_detect = 1'b1;
    first = 0;
    for (int n = 1; n <= 100 && first == 0; n++) begin
      tick();
      if (pma_rcv_detect_done) first = n;
    end
    chk("rereq_latency", 32'(first), 22);
    chk("rereq_det", 32'(pma_rcv_detected), 1);
    pma_rcv_detect = 1'b0;
    tick();
    chk_idle("rereq_release");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
